// File: rtl/serial_mag_comparator_if.sv
// Operand/result handshake bundle for serial_mag_comparator.
// The slave side is the comparator; the master side is its producer/consumer.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, gt, lt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, gt, lt, busy
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Sequential unsigned magnitude comparator: scans operands MSB-first, DIGIT bits
// per cycle, exits at the first differing digit and reports one-hot eq/gt/lt.
module serial_mag_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                    clk,
  input logic                    rst,
  serial_mag_comparator_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_last;

  assign w_da   = r_sa[WIDTH-1 -: DIGIT];
  assign w_db   = r_sb[WIDTH-1 -: DIGIT];
  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is implied here: state is IDLE and rst is low
          if (bus.in_valid) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_da > w_db) begin
            r_gt        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_da < w_db) begin
            r_lt        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_last) begin
            r_eq        <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_sa  <= r_sa << DIGIT;
            r_sb  <= r_sb << DIGIT;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.eq        = r_eq;
  assign bus.gt        = r_gt;
  assign bus.lt        = r_lt;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed scoreboard bench for serial_mag_comparator (DIGIT=4) plus a random
// sweep over DIGIT=1, 8 and 32 instances sharing one stimulus.
module tb_serial_mag_comparator;
  localparam int W = 32;

  typedef struct {
    logic [2:0]  res;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  exp_t        swq[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comparator_if #(.WIDTH(W)) bus ();
  serial_mag_comparator #(.WIDTH(W), .DIGIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic         sw_valid;
  logic [W-1:0] sw_a;
  logic [W-1:0] sw_b;
  logic         sw_ov[3];
  logic         sw_ir[3];
  logic [2:0]   sw_res[3];

  serial_mag_comparator_if #(.WIDTH(W)) if_d1 ();
  serial_mag_comparator_if #(.WIDTH(W)) if_d8 ();
  serial_mag_comparator_if #(.WIDTH(W)) if_d32 ();
  serial_mag_comparator #(.WIDTH(W), .DIGIT(1))  dut_d1  (.clk(clk), .rst(rst), .bus(if_d1));
  serial_mag_comparator #(.WIDTH(W), .DIGIT(8))  dut_d8  (.clk(clk), .rst(rst), .bus(if_d8));
  serial_mag_comparator #(.WIDTH(W), .DIGIT(32)) dut_d32 (.clk(clk), .rst(rst), .bus(if_d32));

  assign if_d1.in_valid  = sw_valid;
  assign if_d1.a         = sw_a;
  assign if_d1.b         = sw_b;
  assign if_d1.out_ready = 1'b1;
  assign if_d8.in_valid  = sw_valid;
  assign if_d8.a         = sw_a;
  assign if_d8.b         = sw_b;
  assign if_d8.out_ready = 1'b1;
  assign if_d32.in_valid  = sw_valid;
  assign if_d32.a         = sw_a;
  assign if_d32.b         = sw_b;
  assign if_d32.out_ready = 1'b1;

  assign sw_ov[0]  = if_d1.out_valid;
  assign sw_ov[1]  = if_d8.out_valid;
  assign sw_ov[2]  = if_d32.out_valid;
  assign sw_ir[0]  = if_d1.in_ready;
  assign sw_ir[1]  = if_d8.in_ready;
  assign sw_ir[2]  = if_d32.in_ready;
  assign sw_res[0] = {if_d1.eq, if_d1.gt, if_d1.lt};
  assign sw_res[1] = {if_d8.eq, if_d8.gt, if_d8.lt};
  assign sw_res[2] = {if_d32.eq, if_d32.gt, if_d32.lt};

  // Reference: latency from the most significant differing bit, result from native compare
  function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input int dg, input int unsigned acc);
    exp_t         e;
    logic [W-1:0] d;
    int           p;
    d = a ^ b;
    p = -1;
    for (int i = 0; i < W; i++) if (d[i]) p = i;
    if (p < 0) begin
      e.res = 3'b100;
      e.due = acc + int'(W / dg);
    end else begin
      e.res = (a > b) ? 3'b010 : 3'b001;
      e.due = acc + int'((W - 1 - p) / dg) + 1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input bit scored);
    chk("offer_in_ready", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    if (scored) sbq.push_back(mk(a, b, 4, cyc + 1));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t        e;
    int unsigned n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
    end else if (sbq.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_res"}, 32'({bus.eq, bus.gt, bus.lt}), 32'(e.res));
      chk({tag, "_lat"}, cyc, e.due);
    end
  endtask

  initial begin
    int   seen;
    bit   got[3];
    int   n;
    int   dg[3];
    logic [W-1:0] ra, rb;
    dg = '{1, 8, 32};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    sw_valid      = 1'b0;
    sw_a          = '0;
    sw_b          = '0;
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Equal operands: full-length scan, ready held low until after handshake
    offer(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    chk("t1_run_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_run_busy", 32'(bus.busy), 32'd1);
    collect("t1");
    chk("t1_done_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_done_busy", 32'(bus.busy), 32'd1);
    step();
    chk("t1_idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_idle_res", 32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    chk("t1_idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    offer(32'h80000000, 32'h7FFFFFFF, 1'b1);
    collect("t2_gt_k0");
    step();
    offer(32'h12345670, 32'h12345671, 1'b1);
    collect("t2_lt_k7");
    step();

    // Backpressure with a new pair held on the input
    bus.out_ready = 1'b0;
    offer(32'h00000010, 32'h00000020, 1'b1);
    collect("t3_first");
    bus.a        = 32'h00000055;
    bus.b        = 32'h00000055;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_res", 32'({bus.eq, bus.gt, bus.lt}), 32'd1);
      chk("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_release_in_ready", 32'(bus.in_ready), 32'd1);
    sbq.push_back(mk(32'h00000055, 32'h00000055, 4, cyc + 1));
    step();
    bus.in_valid = 1'b0;
    collect("t3_held_pair");
    step();

    // Reset three edges into a run aborts the operation
    offer(32'h00000001, 32'h00000002, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("t4_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_rst_busy", 32'(bus.busy), 32'd0);
    chk("t4_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t4_after_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("t4_no_result", 32'(seen), 32'd0);

    offer(32'd5, 32'd5, 1'b1);
    collect("t5_eq");
    step();
    offer(32'd9, 32'd3, 1'b1);
    collect("t5_gt");
    step();
    offer(32'd0, 32'hFFFFFFFF, 1'b1);
    collect("t5_lt");
    step();
    offer(32'd0, 32'd0, 1'b1);
    collect("ext_zero");
    step();
    offer(32'hFFFFFFFF, 32'd0, 1'b1);
    collect("ext_ones");
    step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    // Random sweep across digit widths; one shared offer per pair
    for (int it = 0; it < 16; it++) begin
      ra = $urandom;
      case (it % 4)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'h1 << $urandom_range(31, 0));
        default: rb = ra ^ (32'h1 << $urandom_range(31, 16));
      endcase
      sw_a     = ra;
      sw_b     = rb;
      sw_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk("sw_in_ready", 32'(sw_ir[i]), 32'd1);
        swq[i].push_back(mk(ra, rb, dg[i], cyc + 1));
        got[i] = 1'b0;
      end
      step();
      sw_valid = 1'b0;
      n = 0;
      while (!(got[0] && got[1] && got[2]) && n < 40) begin
        for (int i = 0; i < 3; i++) begin
          if (!got[i] && sw_ov[i] === 1'b1) begin
            exp_t e;
            e = swq[i].pop_front();
            chk($sformatf("sw_d%0d_res", dg[i]), 32'(sw_res[i]), 32'(e.res));
            chk($sformatf("sw_d%0d_lat", dg[i]), cyc, e.due);
            got[i] = 1'b1;
          end
        end
        step();
        n++;
      end
      for (int i = 0; i < 3; i++)
        if (!got[i]) chk($sformatf("sw_d%0d_timeout", dg[i]), 32'(sw_ov[i]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Multi-cycle magnitude comparator for wide unsigned operands.
- Accepts an operand pair {a, b} over a valid/ready input handshake.
- Scans the operands MSB-first, DIGIT bits per cycle, stopping early at the first differing digit.
- Returns a one-hot eq/gt/lt result over a valid/ready output handshake.
- Serves as the sequential, area-lean counterpart to the parallel equality comparators, for datapaths where WIDTH-bit parallel logic is too costly.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, eq=gt=lt=0, busy=0. Shift registers and digit counter are cleared.
- in_ready = (state==IDLE) && !rst. It is derived from registered state only, with no combinational path from in_valid.
- Let N = WIDTH/DIGIT. The digit counter is ceil(log2(N)) bits wide, minimum 1.
- States:
  - IDLE: on in_valid && in_ready, load a and b into shift registers sa and sb, clear the counter, and go to RUN.
  - RUN: each cycle compare da = sa[WIDTH-1 -: DIGIT] with db = sb[WIDTH-1 -: DIGIT] as unsigned values.
    - If da > db: set gt=1 and go to DONE.
    - If da < db: set lt=1 and go to DONE.
    - If da == db and counter == N-1: set eq=1 and go to DONE.
    - Otherwise: shift sa and sb left by DIGIT, increment the counter, and stay in RUN.
  - DONE: out_valid=1. eq/gt/lt are held stable. On out_ready, clear out_valid and eq/gt/lt and return to IDLE.
- in_ready=0 throughout RUN and DONE. in_valid is ignored there; no queuing.
- Latency: if the first differing digit has index k (0 = most significant), out_valid rises k+1 clock edges after the accepting edge. Equal operands take N edges. Minimum latency is 1; maximum is N.
- eq, gt and lt are registered, mutually exclusive, and exactly one is high while out_valid=1. All three are 0 whenever out_valid=0.
- Earliest throughput: a new pair can be accepted on the cycle after the output handshake, since IDLE is re-entered first.
- rst asserted in any state, including mid-RUN or in DONE with out_valid pending, aborts the operation.
  - The next cycle is IDLE with out_valid=0.
  - No result is ever produced for the aborted operation.
- When N=1 (DIGIT==WIDTH), every operation completes in exactly 1 edge.
- Extremes behave identically to any other values: 0 vs 0 gives eq; all-ones vs 0 gives gt at k=0.

Test Plan:
1. WIDTH=32, DIGIT=4, a=b=0xDEADBEEF -> out_valid exactly 8 edges after accept; eq=1, gt=lt=0; in_ready=0 until the cycle after the out_ready handshake.
2. a=0x80000000, b=0x7FFFFFFF -> gt=1 exactly 1 edge after accept (early exit at k=0). Also a=0x12345670, b=0x12345671 -> lt=1 after 8 edges.
3. Backpressure: result pending with out_ready=0 for 5 cycles while in_valid=1 with new operands -> out_valid and eq/gt/lt stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE next cycle, and the held in_valid pair is accepted.
4. Reset mid-RUN: a=0x00000001, b=0x00000002, rst pulsed for 1 cycle at edge 3 -> out_valid never rises for that pair; in_ready=1 the cycle after rst deasserts.
5. Back-to-back with out_ready tied high: pairs (5,5), (9,3), (0,0xFFFFFFFF) -> results eq, gt, lt in order, each arriving at its computed latency; no result dropped or duplicated.
6. Parameter sweep DIGIT=1, 8, 32 with random pairs -> results match a reference (a==b, a>b, a<b), and latencies match the k+1 / N rule.
